// File: rtl/imm_extend_seq_unit_pkg.sv
// Shared types for the sequenced immediate extender: immediate-source codes,
// controller states and the position of the rotate field inside the instruction.
package imm_pkg;

    typedef enum logic [1:0] {
        IMM8   = 2'b00,
        IMM12  = 2'b01,
        BRANCH = 2'b10,
        ROT8   = 2'b11
    } imm_src_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ROTATE = 2'b01,
        DONE   = 2'b10
    } imm_state_t;

    localparam int ROT_FIELD_LSB = 8;

endpackage

// File: rtl/imm_extend_seq_unit_if.sv
// Request/response bundle between decode (master) and the immediate extender (slave).
interface imm_extend_seq_unit_if #(
    parameter int DATA_W  = 32,
    parameter int INSTR_W = 24
);
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] instr;
    logic [1:0]         imm_src;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  ext_imm;
    logic               busy;

    modport master (
        output in_valid, instr, imm_src, out_ready,
        input  in_ready, out_valid, ext_imm, busy
    );

    modport slave (
        input  in_valid, instr, imm_src, out_ready,
        output in_ready, out_valid, ext_imm, busy
    );
endinterface

// File: rtl/imm_extend_seq_unit_ror_step.sv
// Combinational rotate-right of a DATA_W word by 0..ROT_STEP bits; one step of
// the serial rotator.
module imm_ror_step #(
    parameter int DATA_W   = 32,
    parameter int ROT_STEP = 2,
    parameter int AW       = $clog2(ROT_STEP + 1)
) (
    input  logic [DATA_W-1:0] din,
    input  logic [AW-1:0]     amt,
    output logic [DATA_W-1:0] dout
);
    localparam int IW = $clog2(DATA_W);

    // The modulo keeps the rotate correct even when amt reaches or exceeds DATA_W.
    always_comb begin
        dout = '0;
        for (int i = 0; i < DATA_W; i++) begin
            dout[i] = din[IW'((i + int'(amt)) % DATA_W)];
        end
    end
endmodule

// File: rtl/imm_extend_seq_unit.sv
// Handshaked immediate extender: the zero/sign-extended forms finish in one cycle,
// and the ARM rotated-imm8 form is rotated ROT_STEP bits per cycle.
module imm_extend_seq_unit
    import imm_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int INSTR_W  = 24,
    parameter int ROT_STEP = 2
) (
    input logic                  clk,
    input logic                  reset,
    imm_extend_seq_unit_if.slave bus
);
    localparam int AW = $clog2(ROT_STEP + 1);
    localparam int RW = 6;

    if (DATA_W < INSTR_W + 2 || INSTR_W < 12 ||
        !(ROT_STEP == 2 || ROT_STEP == 4 || ROT_STEP == 8 || ROT_STEP == 32)) begin : g_param_check
        $fatal(1, "imm_extend_seq_unit: illegal DATA_W/INSTR_W/ROT_STEP combination");
    end

    imm_state_t        state;
    imm_src_t          src;
    logic              accept;
    logic              req_rot;
    logic [RW-1:0]     req_amt;
    logic [RW-1:0]     rem_amt;
    logic [DATA_W-1:0] req_imm;
    logic [AW-1:0]     step;
    logic [DATA_W-1:0] rot_out;

    assign bus.in_ready = (state == IDLE) || (state == DONE && bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign src          = imm_src_t'(bus.imm_src);

    // Rotate amount is twice the 4-bit field, so it never exceeds 30.
    always_comb begin
        req_amt = {1'b0, bus.instr[ROT_FIELD_LSB+3 -: 4], 1'b0};
        req_imm = '0;
        case (src)
            IMM8:    req_imm = {{(DATA_W-8){1'b0}}, bus.instr[7:0]};
            IMM12:   req_imm = {{(DATA_W-12){1'b0}}, bus.instr[11:0]};
            BRANCH:  req_imm = {{(DATA_W-INSTR_W-2){bus.instr[INSTR_W-1]}}, bus.instr, 2'b00};
            ROT8:    req_imm = {{(DATA_W-8){1'b0}}, bus.instr[7:0]};
            default: req_imm = '0;
        endcase
        req_rot = (src == ROT8) && (req_amt != '0);
    end

    // The final rotate step only covers the residual bits left over.
    assign step = (rem_amt > RW'(ROT_STEP)) ? AW'(ROT_STEP) : rem_amt[AW-1:0];

    imm_ror_step #(
        .DATA_W   (DATA_W),
        .ROT_STEP (ROT_STEP),
        .AW       (AW)
    ) u_ror_step (
        .din  (bus.ext_imm),
        .amt  (step),
        .dout (rot_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.ext_imm   <= '0;
            rem_amt       <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        bus.ext_imm <= req_imm;
                        rem_amt     <= req_amt;
                        if (req_rot) begin
                            state         <= ROTATE;
                            bus.busy      <= 1'b1;
                            bus.out_valid <= 1'b0;
                        end else begin
                            state         <= DONE;
                            bus.busy      <= 1'b0;
                            bus.out_valid <= 1'b1;
                        end
                    end else if (state == DONE && bus.out_ready) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                    end
                end
                ROTATE: begin
                    bus.ext_imm <= rot_out;
                    rem_amt     <= rem_amt - RW'(step);
                    if (rem_amt <= RW'(ROT_STEP)) begin
                        state         <= DONE;
                        bus.busy      <= 1'b0;
                        bus.out_valid <= 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.busy      <= 1'b0;
                    bus.out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
